// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer reader: default 640x480@60
// timing, counter/pixel types and the per-pixel flag bundle carried down the pipeline.
package vga_pkg;

  localparam int PIX_W = 8;
  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Everything the output stage needs to know about one pixel position.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
    logic in_img;
  } flags_t;

  localparam flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0, in_img: 1'b0};

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-rate divider plus horizontal/vertical scan counters; produces the stage-0
// sync/active flags for the current counter position and the frame-start pulse.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic             pix_tick,
  output logic             vga_clk,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             hs,
  output logic             vs,
  output logic             active,
  output logic             frame_start
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS  = H_ACTIVE + H_FP;
  localparam int H_SE  = H_SS + H_SYNC - 1;
  localparam int V_SS  = V_ACTIVE + V_FP;
  localparam int V_SE  = V_SS + V_SYNC - 1;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;

  assign pix_tick = (div == DIV_W'(CLK_DIV - 1));
  assign div_next = pix_tick ? '0 : div + DIV_W'(1);

  // vga_clk tracks the divider phase so the DAC's rising edge lands mid-pixel.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use <= so every flop samples pre-edge values; = here would order-couple them.
    if (!rst) begin
      div     <= '0;
      vga_clk <= 1'b0;
    end else begin
      div     <= div_next;
      vga_clk <= (div_next >= DIV_W'(CLK_DIV / 2));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_tick && (h_cnt == '0) && (v_cnt == '0);
      if (pix_tick) begin
        if (h_cnt == CNT_W'(H_TOT - 1)) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == CNT_W'(V_TOT - 1)) ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign hs     = !((h_cnt >= CNT_W'(H_SS)) && (h_cnt <= CNT_W'(H_SE)));
  assign vs     = !((v_cnt >= CNT_W'(V_SS)) && (v_cnt <= CNT_W'(V_SE)));
  assign active = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));

endmodule

// File: rtl/vga_framebuffer_reader.sv
// Scans the grayscale frame buffer out to the VGA DAC: address accumulator, RAM read,
// then a two-tick pipeline that keeps sync, blank and colour aligned at the pins.
module vga_framebuffer_reader
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [PIX_W-1:0]  mem_data,
  output logic              vga_clk,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic [PIX_W-1:0]  vga_r,
  output logic [PIX_W-1:0]  vga_g,
  output logic [PIX_W-1:0]  vga_b,
  output logic              frame_start
);

  logic        pix_tick;
  cnt_t        h_cnt;
  cnt_t        v_cnt;
  logic        hs;
  logic        vs;
  logic        active;
  logic        in_img;
  flags_t      s0;
  flags_t      s1;
  flags_t      s2;
  pixel_t      pix_q;
  pixel_t      pix_out;
  logic [ADDR_W-1:0] acc;
  logic [ADDR_W-1:0] addr_cur;

  vga_timing_counter #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_tick   (pix_tick),
    .vga_clk    (vga_clk),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hs         (hs),
    .vs         (vs),
    .active     (active),
    .frame_start(frame_start)
  );

  assign in_img = (h_cnt < CNT_W'(IMG_W)) && (v_cnt < CNT_W'(IMG_H));

  // The accumulator walks v*IMG_W+h without a multiplier; the frame origin re-anchors it.
  always_comb begin
    // NOTE: assign a default before any conditional so no path leaves the signal unassigned (latch).
    addr_cur = acc;
    if ((h_cnt == '0) && (v_cnt == '0)) addr_cur = '0;
    s0 = '{hs: hs, vs: vs, active: active, in_img: in_img};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      acc      <= '0;
    end else if (pix_tick) begin
      mem_rd <= s0.in_img;
      if (s0.in_img) begin
        mem_addr <= addr_cur;
        acc      <= addr_cur + ADDR_W'(1);
      end
    end
  end

  // s1 belongs to the address on mem_addr; s2 to the pixel held in pix_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= FLAGS_IDLE;
      s2    <= FLAGS_IDLE;
      pix_q <= '0;
    end else if (pix_tick) begin
      s1    <= s0;
      s2    <= s1;
      pix_q <= mem_data;
    end
  end

  assign pix_out = (s2.in_img && s2.active) ? pix_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
    end else if (pix_tick) begin
      vga_hsync   <= s2.hs;
      vga_vsync   <= s2.vs;
      vga_blank_n <= s2.active;
      vga_r       <= pix_out;
      vga_g       <= pix_out;
      vga_b       <= pix_out;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule
